// File: rtl/tipi_link_pkg.sv
// ---------------------------------------------------------------------------
// tipi_link_pkg
// Shared constants for the TIPI serial register link sequencer:
//   - command opcodes presented on cmd_op
//   - FSM state codes (kept as plain localparams for legacy tools)
//   - PHASES: r_clk half-periods that make up one transaction
//   - op_is_read(): decodes an opcode into the link direction
// ---------------------------------------------------------------------------
package tipi_link_pkg;

    localparam int PHASES = 18;

    localparam logic [1:0] OP_RD_TC = 2'b00;
    localparam logic [1:0] OP_RD_TD = 2'b01;
    localparam logic [1:0] OP_WR_RC = 2'b10;
    localparam logic [1:0] OP_WR_RD = 2'b11;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] LOAD_HI  = 3'd2;
    localparam logic [2:0] BIT_LO   = 3'd3;
    localparam logic [2:0] BIT_HI   = 3'd4;
    localparam logic [2:0] LATCH_LO = 3'd5;
    localparam logic [2:0] LATCH_HI = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    // Reads pull TC/TD from the CPLD (TI-originated registers).
    function automatic logic op_is_read(input logic [1:0] op);
        return (op == OP_RD_TC) || (op == OP_RD_TD);
    endfunction

endpackage

// File: rtl/tipi_sync2.sv
// ---------------------------------------------------------------------------
// tipi_sync2
// Two-flop synchronizer for a single asynchronous level from the CPLD.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; clears both stages
//   d_i    in   asynchronous input level
//   q_o    out  synchronized level, two clk cycles of latency
// ---------------------------------------------------------------------------
module tipi_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments here make both stages sample the values
    // from before the edge; blocking would collapse the chain into one flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tipi_link_seq.sv
// ---------------------------------------------------------------------------
// tipi_link_seq
// Host-side sequencer for the TIPI CPLD serial register link. One parallel
// command (read TC/TD, write RC/RD) becomes a timed 18-phase load/shift/latch
// pulse train on r_clk/r_le/r_dout with r_rt/r_cd selecting the register.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op, cmd_wdata the command
//   rsp_valid            one-cycle completion pulse; rsp_rdata last read byte
//   busy                 transaction in progress (SETUP through DONE)
//   r_clk, r_cd, r_rt,
//   r_le, r_dout         registered link outputs to the CPLD
//   r_din, r_reset       asynchronous link inputs from the CPLD
// ---------------------------------------------------------------------------
module tipi_link_seq
    import tipi_link_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [0:7] cmd_wdata,
    output logic       rsp_valid,
    output logic [0:7] rsp_rdata,
    output logic       busy,
    output logic       r_clk,
    output logic       r_cd,
    output logic       r_rt,
    output logic       r_le,
    output logic       r_dout,
    input  logic       r_din,
    input  logic       r_reset
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);

    logic       r_din_s;
    logic       r_reset_s;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] div_q,   div_d;
    logic [2:0]       bit_q,   bit_d;
    logic             rd_q,    rd_d;
    logic [0:7]       sh_q,    sh_d;
    logic [0:7]       rdata_q, rdata_d;
    logic             clk_q,   clk_d;
    logic             le_q,    le_d;
    logic             rt_q,    rt_d;
    logic             cd_q,    cd_d;
    logic             dout_q,  dout_d;

    tipi_sync2 u_sync_din (
        .clk   (clk),
        .reset (reset),
        .d_i   (r_din),
        .q_o   (r_din_s)
    );

    tipi_sync2 u_sync_reset (
        .clk   (clk),
        .reset (reset),
        .d_i   (r_reset),
        .q_o   (r_reset_s)
    );

    // Link outputs are computed for the state being entered and registered,
    // so r_rt/r_cd/r_le/r_dout only move together with a falling r_clk.
    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no
        // branch leaves one unassigned and no latch is inferred.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        sh_d    = sh_q;
        rdata_d = rdata_q;
        clk_d   = clk_q;
        le_d    = le_q;
        rt_d    = rt_q;
        cd_d    = cd_q;
        dout_d  = dout_q;

        if (r_reset_s) begin
            // CPLD-requested abort: link back to idle levels, read data kept.
            state_d = IDLE;
            clk_d   = 1'b0;
            le_d    = 1'b0;
            rt_d    = 1'b0;
            cd_d    = 1'b0;
            dout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_d = SETUP;
                        div_d   = DIV_LAST;
                        bit_d   = 3'd0;
                        rd_d    = op_is_read(cmd_op);
                        sh_d    = cmd_wdata;
                        clk_d   = 1'b0;
                        rt_d    = op_is_read(cmd_op);
                        cd_d    = cmd_op[0];
                        le_d    = op_is_read(cmd_op);
                        dout_d  = op_is_read(cmd_op) ? 1'b0 : cmd_wdata[0];
                    end
                end
                DONE: state_d = IDLE;
                default: begin
                    if (div_q != '0) begin
                        div_d = div_q - DIV_ONE;
                    end else begin
                        div_d = DIV_LAST;
                        case (state_q)
                            SETUP: begin
                                state_d = rd_q ? LOAD_HI : BIT_HI;
                                clk_d   = 1'b1;
                            end
                            LOAD_HI: begin
                                state_d = BIT_LO;
                                clk_d   = 1'b0;
                                le_d    = 1'b0;
                            end
                            BIT_LO: begin
                                state_d = BIT_HI;
                                clk_d   = 1'b1;
                                // Capture in the last LO cycle: the CPLD bit has
                                // been stable for a whole phase by now.
                                if (rd_q) sh_d = {sh_q[1:7], r_din_s};
                            end
                            BIT_HI: begin
                                clk_d = 1'b0;
                                if (bit_q != 3'd7) begin
                                    state_d = BIT_LO;
                                    bit_d   = bit_q + 3'd1;
                                    if (!rd_q) begin
                                        sh_d   = {sh_q[1:7], 1'b0};
                                        dout_d = sh_q[1];
                                    end
                                end else if (rd_q) begin
                                    state_d = DONE;
                                    rdata_d = sh_q;
                                end else begin
                                    state_d = LATCH_LO;
                                    le_d    = 1'b1;
                                    dout_d  = 1'b0;
                                end
                            end
                            LATCH_LO: begin
                                state_d = LATCH_HI;
                                clk_d   = 1'b1;
                            end
                            LATCH_HI: begin
                                state_d = DONE;
                                clk_d   = 1'b0;
                                le_d    = 1'b0;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            rd_q    <= 1'b0;
            sh_q    <= 8'h00;
            rdata_q <= 8'h00;
            clk_q   <= 1'b0;
            le_q    <= 1'b0;
            rt_q    <= 1'b0;
            cd_q    <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
            clk_q   <= clk_d;
            le_q    <= le_d;
            rt_q    <= rt_d;
            cd_q    <= cd_d;
            dout_q  <= dout_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !r_reset_s;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign r_clk     = clk_q;
    assign r_le      = le_q;
    assign r_rt      = rt_q;
    assign r_cd      = cd_q;
    assign r_dout    = dout_q;

endmodule

// File: tb/tb_tipi_link_seq.sv
// ---------------------------------------------------------------------------
// tb_tipi_link_seq
// Bench for tipi_link_seq: a CPLD shift-register model on the link side, a
// transaction-level model of the expected outputs checked every cycle, and
// directed scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_tipi_link_seq;
    import tipi_link_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int TXN     = PHASES * CLK_DIV;   // cycles from SETUP to DONE-1

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [0:7] cmd_wdata;
    logic       rsp_valid;
    logic [0:7] rsp_rdata;
    logic       busy;
    logic       r_clk, r_cd, r_rt, r_le, r_dout;
    logic       r_din;
    logic       r_reset;

    always #5 clk = ~clk;

    tipi_link_seq #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .r_clk     (r_clk),
        .r_cd      (r_cd),
        .r_rt      (r_rt),
        .r_le      (r_le),
        .r_dout    (r_dout),
        .r_din     (r_din),
        .r_reset   (r_reset)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CPLD register model ----------------
    logic [0:7] cpld_tc = 8'h00, cpld_td = 8'h00, cpld_rc = 8'h00, cpld_rd = 8'h00;
    logic [0:7] tsh = 8'h00, rsh = 8'h00;
    assign r_din = tsh[0];

    always @(posedge r_clk) begin
        if (r_rt) begin
            if (r_le) tsh <= r_cd ? cpld_td : cpld_tc;
            else      tsh <= {tsh[1:7], 1'b0};
        end else begin
            if (r_le) begin
                if (r_cd) cpld_rd <= rsh;
                else      cpld_rc <= rsh;
            end else begin
                rsh <= {rsh[1:7], r_dout};
            end
        end
    end

    int   rises = 0;
    logic dout_log[$];
    always @(posedge r_clk) begin
        rises <= rises + 1;
        dout_log.push_back(r_dout);
    end

    // ---------------- transaction-level output model ----------------
    // m_t counts cycles since accept: 1..TXN are the 18 phases, TXN+1 is DONE.
    logic       m_active = 1'b0, m_rr1 = 1'b0, m_rr2 = 1'b0;
    int         m_t = 0;
    logic [1:0] m_op = 2'b00;
    logic [0:7] m_wd = 8'h00, m_rd_val = 8'h00, m_rdata = 8'h00;
    logic       m_rt = 1'b0, m_cd = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0; m_t <= 0; m_rt <= 1'b0; m_cd <= 1'b0;
            m_rdata <= 8'h00; m_rr1 <= 1'b0; m_rr2 <= 1'b0;
        end else begin
            m_rr1 <= r_reset;
            m_rr2 <= m_rr1;
            if (m_rr2) begin
                m_active <= 1'b0; m_rt <= 1'b0; m_cd <= 1'b0;
            end else if (m_active) begin
                if (m_t == TXN + 1) m_active <= 1'b0;
                else begin
                    m_t <= m_t + 1;
                    if (m_t + 1 == TXN + 1 && !m_op[1]) m_rdata <= m_rd_val;
                end
            end else if (cmd_valid) begin
                m_active <= 1'b1; m_t <= 1; m_op <= cmd_op; m_wd <= cmd_wdata;
                m_rt <= !cmd_op[1]; m_cd <= cmd_op[0];
                m_rd_val <= (cmd_op == OP_RD_TD) ? cpld_td : cpld_tc;
            end
        end
    end

    function automatic logic [15:0] exp_outputs();
        logic in_seq, rd, e_clk, e_le, e_dout;
        int   p;
        in_seq = m_active && (m_t <= TXN);
        p      = in_seq ? (m_t - 1) / CLK_DIV : 0;
        rd     = (m_op == OP_RD_TC) || (m_op == OP_RD_TD);
        e_clk  = in_seq && (p % 2 == 1);
        e_le   = in_seq && (rd ? (p < 2) : (p >= PHASES - 2));
        e_dout = in_seq && !rd && (p < PHASES - 2) && m_wd[p / 2];
        return {m_active, !m_active && !m_rr2, m_active && (m_t == TXN + 1),
                e_clk, e_le, m_rt, m_cd, e_dout, m_rdata};
    endfunction

    // ---------------- per-cycle compare and monitors ----------------
    int       rsp_count = 0, hi_edges = 0, le_cycles = 0, busy_ready = 0;
    int       rsp_cyc[$];
    logic [3:0] prev_link = 4'h0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check($sformatf("outputs@cyc%0d", cyc),
                  {16'h0, busy, cmd_ready, rsp_valid, r_clk, r_le, r_rt, r_cd, r_dout, rsp_rdata},
                  {16'h0, exp_outputs()});
            if (rsp_valid) begin
                rsp_count <= rsp_count + 1;
                rsp_cyc.push_back(cyc);
            end
            if (r_le) le_cycles <= le_cycles + 1;
            if (busy && cmd_ready) busy_ready <= busy_ready + 1;
            if (cyc > 1 && ({r_rt, r_cd, r_le, r_dout} != prev_link) && r_clk)
                hi_edges <= hi_edges + 1;
            prev_link <= {r_rt, r_cd, r_le, r_dout};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [0:7] wd, output int acc);
        int g = 0;
        while (!cmd_ready && g < 300) begin step(); g++; end
        check("ready_before_issue", cmd_ready, 1);
        cmd_op = op; cmd_wdata = wd; cmd_valid = 1'b1;
        acc = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_op = ~op;           // later changes must not affect the transaction
        cmd_wdata = ~wd;
    endtask

    task automatic wait_rsp(output int at);
        int n0 = rsp_count;
        int g = 0;
        while (rsp_count == n0 && g < 300) begin step(); g++; end
        check("rsp_seen", rsp_count - n0, 1);
        at = (rsp_cyc.size() > 0) ? rsp_cyc[$] : -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, at, r0, d0, h0, l0, n0, b0, g, sz;
        logic [1:0] ops [3];
        logic exp_bits [8];
        ops      = '{OP_RD_TC, OP_WR_RC, OP_RD_TC};
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wdata = 8'h00; r_reset = 1'b0;
        cpld_tc = 8'hA5; cpld_td = 8'h3C;

        while (cyc < 2) step();
        check("reset_state", {busy, rsp_valid, r_clk, r_le, r_rt, r_cd, r_dout, rsp_rdata}, 15'h0);
        while (cyc < 3) step();
        reset = 1'b0;

        // T1: read TC accepted at cycle 10
        while (cyc < 10) step();
        r0 = rises; l0 = le_cycles;
        issue(OP_RD_TC, 8'h00, acc);
        check("t1_accept_cycle", acc, 10);
        wait_rsp(at);
        check("t1_rsp_cycle", at, 83);
        check("t1_rdata", rsp_rdata, 8'hA5);
        check("t1_rclk_rises", rises - r0, 9);
        check("t1_le_cycles", le_cycles - l0, 8);
        check("t1_select", {r_rt, r_cd}, 2'b10);

        // T2: read TD, then write RC
        issue(OP_RD_TD, 8'h00, acc);
        wait_rsp(at);
        check("t2_rdata_td", rsp_rdata, 8'h3C);
        check("t2_select", {r_rt, r_cd}, 2'b11);
        issue(OP_WR_RC, 8'h81, acc);
        wait_rsp(at);
        check("t2_cpld_rc", cpld_rc, 8'h81);
        check("t2_rdata_kept", rsp_rdata, 8'h3C);

        // T3: write RD, bit-level link timing
        r0 = rises; d0 = dout_log.size(); h0 = hi_edges;
        issue(OP_WR_RD, 8'h5A, acc);
        wait_rsp(at);
        check("t3_rclk_rises", rises - r0, 9);
        for (int i = 0; i < 8; i++)
            if (dout_log.size() > d0 + i)
                check($sformatf("t3_dout_bit%0d", i), dout_log[d0 + i], exp_bits[i]);
            else
                check($sformatf("t3_dout_bit%0d_present", i), 0, 1);
        check("t3_dout_latch", (dout_log.size() > d0 + 8) ? dout_log[d0 + 8] : 1'bx, 1'b0);
        check("t3_edges_while_high", hi_edges - h0, 0);
        check("t3_cpld_rd", cpld_rd, 8'h5A);

        // T4: r_reset pulsed during BIT_HI of a read
        r0 = rises; n0 = rsp_count;
        issue(OP_RD_TC, 8'h00, acc);
        g = 0;
        while (!(rises - r0 >= 3 && r_clk) && g < 200) begin step(); g++; end
        check("t4_in_bit_hi", r_clk, 1'b1);
        r_reset = 1'b1;
        step(); step(); step();
        check("t4_idle_after_abort", busy, 1'b0);
        check("t4_link_idle", {r_clk, r_le, r_rt, r_cd, r_dout}, 5'b0);
        check("t4_ready_low", cmd_ready, 1'b0);
        check("t4_rdata_kept", rsp_rdata, 8'h3C);
        step(); step();
        check("t4_ready_still_low", cmd_ready, 1'b0);
        r_reset = 1'b0;
        step(); step(); step();
        check("t4_ready_back", cmd_ready, 1'b1);
        check("t4_no_rsp", rsp_count - n0, 0);

        // T5: cmd_valid held high, ops 00,10,00 back-to-back
        n0 = rsp_count; b0 = busy_ready;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_op = ops[k];
            cmd_wdata = (k == 1) ? 8'h96 : 8'h00;
            g = 0;
            while (!cmd_ready && g < 300) begin step(); g++; end
            check($sformatf("t5_ready_%0d", k), cmd_ready, 1'b1);
            step();
        end
        cmd_valid = 1'b0;
        g = 0;
        while (rsp_count - n0 < 3 && g < 400) begin step(); g++; end
        check("t5_rsp_count", rsp_count - n0, 3);
        sz = rsp_cyc.size();
        if (sz >= 3) begin
            check("t5_spacing_1", rsp_cyc[sz - 2] - rsp_cyc[sz - 3], 74);
            check("t5_spacing_2", rsp_cyc[sz - 1] - rsp_cyc[sz - 2], 74);
        end
        check("t5_ready_while_busy", busy_ready - b0, 0);
        check("t5_rdata", rsp_rdata, 8'hA5);
        check("t5_cpld_rc", cpld_rc, 8'h96);

        // T6: reset in the middle of a write
        issue(OP_WR_RC, 8'hFF, acc);
        repeat (20) step();
        check("t6_busy_before", busy, 1'b1);
        reset = 1'b1;
        step();
        check("t6_reset_outputs", {busy, rsp_valid, r_clk, r_le, r_rt, r_cd, r_dout, rsp_rdata}, 15'h0);
        reset = 1'b0;
        step(); step(); step();
        check("t6_ready_after", cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
